multicycle_control_fsm: RTL

//  Main sequencer for the multi-cycle MIPS datapath. It drives the shared ALU, the PC/IR

---
 rtl/multicycle_control_fsm_if.sv | 39 +++
 rtl/multicycle_control_fsm.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - control bus between the multi-cycle sequencer and the datapath
interface multicycle_control_fsm_if;
    logic [5:0] Opcode;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic       instr_done;
    logic       illegal_op;
    logic       bus_error;
    logic [3:0] state_o;

    // Sequencer side: consumes IR/ALU/memory status, drives every control line
    modport master (
        input  Opcode, Zero, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, instr_done, illegal_op, bus_error, state_o
    );

    // Datapath side
    modport slave (
        output Opcode, Zero, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, instr_done, illegal_op, bus_error, state_o
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle MIPS main sequencer with memory wait/timeout handling
module multicycle_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    multicycle_control_fsm_if.master   bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ILLEGAL = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     state, state_next;
    logic [7:0] wait_cnt, wait_cnt_next;
    logic       timeout;
    logic       is_rtype;

    // Timeout only fires if memory is still not ready; a late mem_ready completes normally
    assign timeout  = (wait_cnt == TIMEOUT_CNT) && !bus.mem_ready;
    assign is_rtype = (bus.Opcode == OP_RTYPE);
    assign bus.state_o = reset ? 4'd0 : state;

    // State and wait-counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next-state and control decode; reset forces every control line low
    always_comb begin
        state_next      = S_FETCH;
        wait_cnt_next   = 8'd0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 3'b000;
        bus.PCSource    = 2'b00;
        bus.instr_done  = 1'b0;
        bus.illegal_op  = 1'b0;
        bus.bus_error   = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    bus.MemRead = !timeout;
                    bus.ALUSrcB = 2'b01;
                    bus.ALUOp   = 3'b110;
                    if (bus.mem_ready) begin
                        bus.IRWrite = 1'b1;
                        bus.PCWrite = 1'b1;
                        state_next  = S_DECODE;
                    end else if (timeout) begin
                        bus.bus_error = 1'b1;
                    end else begin
                        wait_cnt_next = wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    bus.ALUSrcB = 2'b11;
                    bus.ALUOp   = 3'b110;
                    case (bus.Opcode)
                        OP_RTYPE, OP_ADDI, OP_ORI: state_next = S_EXEC;
                        OP_LW, OP_SW:              state_next = S_MEMADR;
                        OP_BEQ:                    state_next = S_BRANCH;
                        OP_J:                      state_next = S_JUMP;
                        default:                   state_next = S_ILLEGAL;
                    endcase
                end
                S_MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    bus.ALUOp   = 3'b110;
                    state_next  = (bus.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    bus.IorD    = 1'b1;
                    bus.MemRead = !timeout;
                    if (bus.mem_ready) begin
                        state_next = S_MEMWB;
                    end else if (timeout) begin
                        bus.bus_error = 1'b1;
                    end else begin
                        state_next    = S_MEMRD;
                        wait_cnt_next = wait_cnt + 8'd1;
                    end
                end
                S_MEMWB: begin
                    bus.RegWrite   = 1'b1;
                    bus.MemtoReg   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    bus.IorD     = 1'b1;
                    bus.MemWrite = !timeout;
                    if (bus.mem_ready) begin
                        bus.instr_done = 1'b1;
                    end else if (timeout) begin
                        bus.bus_error = 1'b1;
                    end else begin
                        state_next    = S_MEMWR;
                        wait_cnt_next = wait_cnt + 8'd1;
                    end
                end
                S_EXEC, S_ALUWB: begin
                    bus.ALUSrcB = is_rtype ? 2'b00 : 2'b10;
                    bus.ALUOp   = is_rtype ? 3'b111 :
                                  (bus.Opcode == OP_ORI) ? 3'b101 : 3'b110;
                    if (state == S_EXEC) begin
                        bus.ALUSrcA = 1'b1;
                        state_next  = S_ALUWB;
                    end else begin
                        bus.RegWrite   = 1'b1;
                        bus.RegDst     = is_rtype;
                        bus.instr_done = 1'b1;
                    end
                end
                S_BRANCH: begin
                    bus.ALUSrcA     = 1'b1;
                    bus.ALUOp       = 3'b100;
                    bus.PCWriteCond = 1'b1;
                    bus.PCSource    = 2'b01;
                    bus.instr_done  = 1'b1;
                end
                S_JUMP: begin
                    bus.PCWrite    = 1'b1;
                    bus.PCSource   = 2'b10;
                    bus.instr_done = 1'b1;
                end
                S_ILLEGAL: begin
                    bus.illegal_op = 1'b1;
                end
                default: state_next = S_FETCH;
            endcase
        end
    end

endmodule
